// File: rtl/alu_sequencer.sv
// Program-driven initiator for the accumulator ALU: fetches one word per clock from a small
// program memory, captures ALU results after OUT instructions. Optional abort input via ALU_SEQ_ABORT_EN.
module alu_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int PROG_DEPTH = 16,
    localparam int AW = $clog2(PROG_DEPTH)
) (
    input  logic                  clk,
    input  logic                  a_reset_n,
    input  logic                  prog_we,
    input  logic [AW-1:0]         prog_addr,
    input  logic [DATA_WIDTH+3:0] prog_wdata,
    input  logic                  start,
`ifdef ALU_SEQ_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_data_in,
    input  logic [DATA_WIDTH-1:0] alu_data_out,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_PC = AW'(PROG_DEPTH - 1);
    localparam logic [3:0]    OP_NOP  = 4'h0;
    localparam logic [3:0]    OP_OUT  = 4'h9;
    localparam logic [3:0]    OP_HALT = 4'hF;

    state_t                state_r;
    logic [AW-1:0]         pc_r;
    logic [1:0]            drain_cnt_r;
    logic                  cap1_r;
    logic                  cap2_r;
    logic [DATA_WIDTH+3:0] mem_r [PROG_DEPTH];

    logic [DATA_WIDTH+3:0] fetch_word_s;
    logic [3:0]            fetch_op_s;
    logic [DATA_WIDTH-1:0] fetch_operand_s;
    logic                  abort_s;

    assign fetch_word_s    = mem_r[pc_r];
    assign fetch_op_s      = fetch_word_s[DATA_WIDTH+3:DATA_WIDTH];
    assign fetch_operand_s = fetch_word_s[DATA_WIDTH-1:0];

`ifdef ALU_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Program memory: not reset so the program survives a_reset_n; writable only while idle.
    always_ff @(posedge clk) begin
        if (prog_we && (state_r == ST_IDLE)) begin
            mem_r[prog_addr] <= prog_wdata;
        end
    end

    // Sequencer FSM, ALU drive registers and the two-stage OUT capture pipeline.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_r      <= ST_IDLE;
            pc_r         <= '0;
            drain_cnt_r  <= 2'd0;
            cap1_r       <= 1'b0;
            cap2_r       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            alu_opcode   <= OP_NOP;
            alu_data_in  <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            done         <= 1'b0;
            cap1_r       <= 1'b0;
            cap2_r       <= cap1_r;
            result_valid <= cap2_r;
            if (cap2_r) begin
                result <= alu_data_out;
            end else begin
                result <= result;
            end

            case (state_r)
                ST_IDLE: begin
                    alu_opcode  <= OP_NOP;
                    alu_data_in <= '0;
                    drain_cnt_r <= 2'd0;
                    if (start) begin
                        state_r <= ST_RUN;
                        pc_r    <= '0;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    busy        <= 1'b1;
                    drain_cnt_r <= 2'd0;
                    if (abort_s || (fetch_op_s == OP_HALT)) begin
                        // HALT is never issued; the ALU sees a no-op instead.
                        alu_opcode  <= OP_NOP;
                        alu_data_in <= '0;
                        state_r     <= ST_DRAIN;
                    end else begin
                        alu_opcode  <= fetch_op_s;
                        alu_data_in <= fetch_operand_s;
                        cap1_r      <= (fetch_op_s == OP_OUT);
                        if (pc_r == LAST_PC) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            pc_r    <= pc_r + {{(AW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_DRAIN: begin
                    // Long enough for an OUT issued on the last fetch to reach result.
                    alu_opcode  <= OP_NOP;
                    alu_data_in <= '0;
                    if (drain_cnt_r == 2'd2) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 2'd1;
                        busy        <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy        <= 1'b0;
                    alu_opcode  <= OP_NOP;
                    alu_data_in <= '0;
                    drain_cnt_r <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural accumulator ALU and a result scoreboard.
// Define ALU_SEQ_ABORT_EN to also exercise the abort input.
module tb_alu_sequencer;

    localparam int DW = 8;
    localparam int PD = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          a_reset_n;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [DW+3:0] prog_wdata;
    logic          start;
`ifdef ALU_SEQ_ABORT_EN
    logic          abort;
`endif
    logic          busy;
    logic          done;
    logic [3:0]    alu_opcode;
    logic [DW-1:0] alu_data_in;
    logic [DW-1:0] alu_data_out;
    logic [DW-1:0] result;
    logic          result_valid;

    logic [DW-1:0] acc_r;
    logic [DW-1:0] rega_r;

    int n_cmp = 0;
    int n_err = 0;
    int rv_cnt = 0;
    int done_cnt = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_WIDTH(DW), .PROG_DEPTH(PD)) dut (
        .clk          (clk),
        .a_reset_n    (a_reset_n),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_wdata   (prog_wdata),
        .start        (start),
`ifdef ALU_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .busy         (busy),
        .done         (done),
        .alu_opcode   (alu_opcode),
        .alu_data_in  (alu_data_in),
        .alu_data_out (alu_data_out),
        .result       (result),
        .result_valid (result_valid)
    );

    // Accumulator ALU: executes the opcode presented during the previous cycle.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            acc_r        <= 8'h00;
            rega_r       <= 8'h00;
            alu_data_out <= 8'h00;
        end else begin
            case (alu_opcode)
                4'h1: rega_r <= alu_data_in;
                4'h2: acc_r <= acc_r + rega_r;
                4'h3: acc_r <= acc_r - rega_r;
                4'h4: acc_r <= acc_r & rega_r;
                4'h5: acc_r <= acc_r | rega_r;
                4'h6: acc_r <= acc_r ^ rega_r;
                4'h7: acc_r <= acc_r << 1;
                4'h8: acc_r <= acc_r >> 1;
                4'h9: alu_data_out <= acc_r;
                4'hA: acc_r <= 8'h00;
                default: acc_r <= acc_r;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance past the edge, then score any result pulse and count done pulses.
    task automatic tick();
        logic [DW-1:0] e;
        @(posedge clk);
        #1;
        if (result_valid === 1'b1) begin
            rv_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL result_extra: observed pulse with %0h expected none", result);
            end else begin
                e = exp_q.pop_front();
                check("result", {24'h0, result}, {24'h0, e});
            end
        end
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic wr(input int a, input logic [3:0] op, input logic [7:0] d);
        prog_we    = 1'b1;
        prog_addr  = a[AW-1:0];
        prog_wdata = {op, d};
        tick();
        prog_we    = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_done"}, {31'h0, done}, 32'h1);
        check({tag, "_busy_low"}, {31'h0, busy}, 32'h0);
        check({tag, "_queue_empty"}, exp_q.size(), 32'h0);
    endtask

    task automatic run(input string tag, output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(tag, lat);
    endtask

    initial begin
        int lat;
        int d0;
        int rv0;
        a_reset_n  = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = 4'h0;
        prog_wdata = 12'h000;
        start      = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
        abort      = 1'b0;
`endif
        #12;
        check("rst_opcode", {28'h0, alu_opcode}, 32'h0);
        check("rst_data_in", {24'h0, alu_data_in}, 32'h0);
        check("rst_result", {24'h0, result}, 32'h0);
        check("rst_rv", {31'h0, result_valid}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        a_reset_n = 1'b1;
        tick();

        // Basic run: REGA 5, ADD, ADD, OUT, HALT -> 0x0A, done 3 cycles after HALT fetch.
        wr(0, 4'h1, 8'h05); wr(1, 4'h2, 8'h00); wr(2, 4'h2, 8'h00);
        wr(3, 4'h9, 8'h00); wr(4, 4'hF, 8'h00);
        exp_q.push_back(8'h0A);
        rv0 = rv_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy", {31'h0, busy}, 32'h1);
        tick();
        check("t1_first_op", {28'h0, alu_opcode}, 32'h1);
        check("t1_first_data", {24'h0, alu_data_in}, 32'h05);
        wait_done("t1", lat);
        check("t1_latency", lat + 1, 32'd8);
        check("t1_rv_count", rv_cnt - rv0, 32'd1);
        tick();
        check("t1_done_pulse", {31'h0, done}, 32'h0);

        // Wrap-around subtraction from a cleared accumulator.
        wr(0, 4'hA, 8'h00); wr(1, 4'h1, 8'h03); wr(2, 4'h3, 8'h00);
        wr(3, 4'h9, 8'h00); wr(4, 4'hF, 8'h00);
        exp_q.push_back(8'hFD);
        run("t2", lat);
        check("t2_latency", lat, 32'd8);

        // Full 16-word program without HALT; last word is OUT.
        wr(0, 4'hA, 8'h00); wr(1, 4'h1, 8'h81); wr(2, 4'h2, 8'h00); wr(3, 4'h7, 8'h00);
        for (int i = 4; i < 15; i++) wr(i, 4'h0, 8'h00);
        wr(15, 4'h9, 8'h00);
        exp_q.push_back(8'h02);
        d0 = done_cnt;
        rv0 = rv_cnt;
        run("t3", lat);
        check("t3_latency", lat, 32'd19);
        repeat (6) tick();
        check("t3_no_wrap_busy", {31'h0, busy}, 32'h0);
        check("t3_done_count", done_cnt - d0, 32'd1);
        check("t3_rv_count", rv_cnt - rv0, 32'd1);

        // OUT, RESET, OUT, OUT (last two back to back).
        wr(0, 4'hA, 8'h00); wr(1, 4'h1, 8'h07); wr(2, 4'h2, 8'h00); wr(3, 4'h9, 8'h00);
        wr(4, 4'hA, 8'h00); wr(5, 4'h9, 8'h00); wr(6, 4'h9, 8'h00); wr(7, 4'hF, 8'h00);
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        run("t4", lat);
        check("t4_latency", lat, 32'd11);

        // start and prog_we while busy are ignored; re-run reproduces the result.
        wr(0, 4'hA, 8'h00); wr(1, 4'h1, 8'h05); wr(2, 4'h2, 8'h00); wr(3, 4'h2, 8'h00);
        wr(4, 4'h9, 8'h00); wr(5, 4'hF, 8'h00);
        exp_q.push_back(8'h0A);
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'h1; prog_wdata = {4'h1, 8'h55};
        tick(); tick();
        start = 1'b0; prog_we = 1'b0;
        wait_done("t5", lat);
        repeat (4) tick();
        check("t5_no_rerun", {31'h0, busy}, 32'h0);
        check("t5_done_count", done_cnt - d0, 32'd1);
        exp_q.push_back(8'h0A);
        run("t5b", lat);
        check("t5b_latency", lat, 32'd9);

        // Asynchronous reset mid-run, then a clean re-run.
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        a_reset_n = 1'b0;
        #1;
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        check("t6_rst_opcode", {28'h0, alu_opcode}, 32'h0);
        check("t6_rst_data_in", {24'h0, alu_data_in}, 32'h0);
        check("t6_rst_result", {24'h0, result}, 32'h0);
        @(negedge clk);
        a_reset_n = 1'b1;
        repeat (6) tick();
        check("t6_no_done", done_cnt - d0, 32'd0);
        check("t6_idle", {31'h0, busy}, 32'h0);
        exp_q.push_back(8'h0A);
        run("t6b", lat);
        check("t6b_latency", lat, 32'd9);

`ifdef ALU_SEQ_ABORT_EN
        // Abort the cycle after an OUT issue: the capture completes, then done.
        wr(0, 4'hA, 8'h00); wr(1, 4'h1, 8'h05); wr(2, 4'h2, 8'h00); wr(3, 4'h9, 8'h00);
        wr(4, 4'h2, 8'h00); wr(5, 4'h2, 8'h00); wr(6, 4'h2, 8'h00); wr(7, 4'h9, 8'h00);
        wr(8, 4'hF, 8'h00);
        exp_q.push_back(8'h05);
        rv0 = rv_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("t7_out_issued", {28'h0, alu_opcode}, 32'h9);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t7_abort_nop", {28'h0, alu_opcode}, 32'h0);
        wait_done("t7", lat);
        check("t7_latency", lat, 32'd3);
        check("t7_rv_count", rv_cnt - rv0, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
